seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational accumulator ALU; sits between the AC/DR registers and the accumulator write-back path of the CPU datapath.
- Adds a start/busy/done handshake and registered result/flags.
- Adds a multi-cycle shift-add multiply and a zero flag; supports back-to-back single-cycle operations.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- MUL_EN, 1, 1 enables the multiply opcode; 0 makes opcode 100 behave as reserved.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  request; sampled only in IDLE on rising clk.
- AC  input  WIDTH  accumulator operand; latched when start is accepted.
- DR  input  WIDTH  data-register operand; latched when start is accepted.
- selector  input  3  opcode; latched when start is accepted.
- busy  output  1  registered; high while a multiply is in progress.
- done  output  1  registered one-cycle pulse; result/E/Z are valid from this cycle on.
- result  output  WIDTH  registered result; held until the next completion.
- E  output  1  registered carry/extend flag.
- Z  output  1  registered; 1 when result==0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, E=0, Z=0; multiply accumulator and counter cleared. Effective immediately, including mid-multiply; an interrupted multiply is discarded.
- States: IDLE, MUL. The default done value is 0 every cycle unless set by a completion.
- Accept: at an edge where state=IDLE and start=1. A start while in MUL is ignored; there is no queuing.
- Single-cycle ops, accepted at edge T:
  - result, E and Z are written at T; done=1 for the cycle after T.
  - state stays IDLE, so a new start is accepted on every edge.
- Opcodes (all arithmetic modulo 2^WIDTH):
  - 000 add: AC+DR; E=carry out.
  - 001 sub: AC+~DR+1; E=carry out (1 when AC>=DR unsigned).
  - 010 xor: AC^DR; E=0.
  - 011 double: AC+AC; E=AC[WIDTH-1].
  - 100 mul (MUL_EN=1): multi-cycle; result = low WIDTH bits of AC*DR; E=1 if the high WIDTH bits are nonzero.
  - 110 cmp: ~AC; E=0.
  - 101, 111, and 100 when MUL_EN=0: result=0, E=0, Z=1; single-cycle with done.
- Multiply, accepted at edge T0:
  - At T0: state->MUL, busy=1; operands latched; 2*WIDTH accumulator cleared; counter=0.
  - Edges T0+1..T0+WIDTH: one shift-add step per edge, LSB-first on the multiplier.
  - At edge T0+WIDTH: result, E and Z written; busy=0; done=1 for one cycle; state->IDLE.
  - busy is therefore high for exactly WIDTH cycles. A start in the done cycle is accepted.
- Outputs hold their values between completions. done never asserts without a preceding accepted start.
- Operand changes after acceptance have no effect on the operation in flight.

Test Plan (WIDTH=8):
1. add AC=0x37, DR=0x05, one-cycle start -> next cycle done=1, result=0x3C, E=0, Z=0; done low the following cycle.
2. add 0xFF+0x01 -> result=0x00, E=1, Z=1. Then, on the immediately following edge, sub 0x05-0x06 -> result=0xFF, E=0. Then sub 0x30-0x30 -> 0x00, E=1, Z=1. Confirms back-to-back acceptance.
3. double AC=0x81 -> result=0x02, E=1. cmp AC=0x5A -> result=0xA5, E=0. opcode 111 -> result=0x00, Z=1, done=1.
4. mul 0x0F*0x11 -> busy high exactly 8 cycles, then done=1, result=0xFF, E=0. An add start pulsed during busy (operands changed) is ignored and the mul result is unaffected. Then mul 0x10*0x10 -> result=0x00, E=1, Z=1.
5. rst_n low asynchronously (mid-cycle) 3 cycles into a mul -> busy, done, result, E and Z go to 0 immediately. After release: no done, state IDLE; a new add 0x01+0x01 gives 0x02.
6. MUL_EN=0 build: mul 0x03*0x03 -> single-cycle done, result=0x00, E=0, Z=1; busy never asserts.

Source files
------------

// File: rtl/seq_alu.sv
// Registered accumulator ALU with a start/busy/done handshake.
// Single-cycle ops complete on the accept edge; multiply runs as a WIDTH-step shift-add.
module seq_alu #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] AC,
    input  logic [WIDTH-1:0] DR,
    input  logic [2:0]       selector,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             E,
    output logic             Z
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_MUL  = 1'b1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_DBL = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b110;

    logic                 r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_result;
    logic                 r_e;
    logic                 r_z;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_cnt;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_res;
    logic                 w_e;
    logic                 w_is_mul;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_sum      = {1'b0, AC} + {1'b0, DR};
    assign w_diff     = {1'b0, AC} + {1'b0, ~DR} + (WIDTH+1)'(1);
    assign w_is_mul   = (selector == OP_MUL) && (MUL_EN != 0);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // NOTE: default every output first so no path through the case infers a latch.
    always_comb begin
        w_res = '0;
        w_e   = 1'b0;
        case (selector)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_e   = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_e   = w_diff[WIDTH];
            end
            OP_XOR: w_res = AC ^ DR;
            OP_DBL: begin
                w_res = {AC[WIDTH-2:0], 1'b0};
                w_e   = AC[WIDTH-1];
            end
            OP_CMP: w_res = ~AC;
            default: begin
                w_res = '0;
                w_e   = 1'b0;
            end
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_e      <= 1'b0;
            r_z      <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    if (w_is_mul) begin
                        r_state  <= S_MUL;
                        r_busy   <= 1'b1;
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, AC};
                        r_mplier <= DR;
                        r_cnt    <= '0;
                    end else begin
                        r_result <= w_res;
                        r_e      <= w_e;
                        r_z      <= (w_res == '0);
                        r_done   <= 1'b1;
                    end
                end
            end else begin
                // Multiplier consumed LSB-first; multiplicand shifts up to stay aligned.
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
                if (w_last) begin
                    r_result <= w_acc_next[WIDTH-1:0];
                    r_e      <= |w_acc_next[2*WIDTH-1:WIDTH];
                    r_z      <= (w_acc_next[WIDTH-1:0] == '0);
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign E      = r_e;
    assign Z      = r_z;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a full build and a MUL_EN=0 build side by side.
module tb_seq_alu;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_DBL = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_R7  = 3'b111;

    typedef struct {
        logic [7:0] res;
        logic       e;
        logic       z;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start, start2;
    logic [7:0] ac, dr, ac2, dr2;
    logic [2:0] sel, sel2;
    logic       busy, done, e_flag, z_flag;
    logic       busy2, done2, e_flag2, z_flag2;
    logic [7:0] result, result2;
    logic       busy2_seen;

    int n_checks;
    int n_errors;
    exp_t q[$];
    exp_t q2[$];

    seq_alu #(.WIDTH(8), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .AC(ac), .DR(dr), .selector(sel),
        .busy(busy), .done(done), .result(result), .E(e_flag), .Z(z_flag)
    );

    seq_alu #(.WIDTH(8), .MUL_EN(0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .start(start2), .AC(ac2), .DR(dr2), .selector(sel2),
        .busy(busy2), .done(done2), .result(result2), .E(e_flag2), .Z(z_flag2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] s, input logic [7:0] a,
                                   input logic [7:0] d, input bit mul_en);
        exp_t        r;
        int unsigned p;
        r.res = 8'h00;
        r.e   = 1'b0;
        case (s)
            OP_ADD: begin p = a + d; r.res = p[7:0]; r.e = (p > 255); end
            OP_SUB: begin r.res = a - d; r.e = (a >= d); end
            OP_XOR: r.res = a ^ d;
            OP_DBL: begin p = a * 2; r.res = p[7:0]; r.e = (a >= 8'h80); end
            OP_MUL: if (mul_en) begin p = a * d; r.res = p[7:0]; r.e = (p > 255); end
            OP_CMP: r.res = 8'hFF - a;
            default: ;
        endcase
        r.z = (r.res == 8'h00);
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                check("spurious_done", done, 0);
            end else begin
                x = q.pop_front();
                check("sb_result", result, x.res);
                check("sb_E", e_flag, x.e);
                check("sb_Z", z_flag, x.z);
            end
        end
        if (rst_n && done2) begin
            if (q2.size() == 0) begin
                check("nm_spurious_done", done2, 0);
            end else begin
                x = q2.pop_front();
                check("nm_result", result2, x.res);
                check("nm_E", e_flag2, x.e);
                check("nm_Z", z_flag2, x.z);
            end
        end
    end

    always @(posedge clk) if (busy2) busy2_seen = 1'b1;

    task automatic issue(input logic [2:0] s, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        start = 1'b1;
        sel   = s;
        ac    = a;
        dr    = d;
        q.push_back(model(s, a, d, 1'b1));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        start = 1'b0;
        while ((q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_budget", (n < budget), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbusy;
        logic [2:0] rs;
        n_checks   = 0;
        n_errors   = 0;
        busy2_seen = 1'b0;
        rst_n  = 1'b0;
        start  = 1'b0; sel  = OP_ADD; ac  = 8'h00; dr  = 8'h00;
        start2 = 1'b0; sel2 = OP_ADD; ac2 = 8'h00; dr2 = 8'h00;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_E", e_flag, 0);
        check("rst_Z", z_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add, done is a single-cycle pulse
        issue(OP_ADD, 8'h37, 8'h05);
        @(negedge clk);
        start = 1'b0;
        check("t1_done", done, 1);
        check("t1_result", result, 8'h3C);
        @(negedge clk);
        check("t1_done_low", done, 0);

        // Back-to-back acceptance
        issue(OP_ADD, 8'hFF, 8'h01);
        issue(OP_SUB, 8'h05, 8'h06);
        issue(OP_SUB, 8'h30, 8'h30);
        wait_idle(20);
        check("t2_last_Z", z_flag, 1);
        check("t2_last_E", e_flag, 1);

        issue(OP_DBL, 8'h81, 8'h00);
        issue(OP_CMP, 8'h5A, 8'h00);
        issue(OP_R7, 8'h12, 8'h34);
        wait_idle(20);
        check("t3_r7_result", result, 8'h00);
        check("t3_r7_Z", z_flag, 1);

        // Multiply: busy count, ignored start mid-op, start accepted in done cycle
        issue(OP_MUL, 8'h0F, 8'h11);
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) break;
            nbusy++;
            if (i == 3) begin
                start = 1'b1; sel = OP_ADD; ac = 8'h01; dr = 8'h02;
            end
        end
        check("t4_busy_cycles", nbusy, 8);
        check("t4_done", done, 1);
        check("t4_result", result, 8'hFF);
        start = 1'b1; sel = OP_MUL; ac = 8'h10; dr = 8'h10;
        q.push_back(model(OP_MUL, 8'h10, 8'h10, 1'b1));
        wait_idle(40);
        check("t4b_result", result, 8'h00);
        check("t4b_E", e_flag, 1);

        // Async reset mid-multiply
        issue(OP_XOR, 8'h5A, 8'h0F);
        issue(OP_MUL, 8'h0D, 8'h0B);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_result", result, 0);
        check("t5_E", e_flag, 0);
        check("t5_Z", z_flag, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t5_no_done", done, 0);
            check("t5_idle", busy, 0);
        end
        issue(OP_ADD, 8'h01, 8'h01);
        wait_idle(20);
        check("t5_add", result, 8'h02);

        // MUL_EN=0 build: opcode 100 is reserved
        @(negedge clk);
        start2 = 1'b1; sel2 = OP_MUL; ac2 = 8'h03; dr2 = 8'h03;
        q2.push_back(model(OP_MUL, 8'h03, 8'h03, 1'b0));
        @(negedge clk);
        sel2 = OP_ADD; ac2 = 8'h03; dr2 = 8'h04;
        q2.push_back(model(OP_ADD, 8'h03, 8'h04, 1'b0));
        check("t6_done", done2, 1);
        check("t6_result", result2, 8'h00);
        check("t6_Z", z_flag2, 1);
        @(negedge clk);
        start2 = 1'b0;
        check("t6_add", result2, 8'h07);
        @(negedge clk);
        check("t6_busy_never", busy2_seen, 0);

        // Random mix on the full build
        for (int k = 0; k < 30; k++) begin
            rs = 3'($urandom_range(0, 7));
            issue(rs, 8'($urandom), 8'($urandom));
            if (rs == OP_MUL) wait_idle(40);
        end
        wait_idle(40);
        check("sb_empty", q.size(), 0);
        check("nm_sb_empty", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
